// File: rtl/stitch_sched.sv
// stitch_sched: merges two camera byte streams into frame memory, splits a keypoint pair into row/col, then streams the blended frame
module stitch_sched #(
   parameter int N  = 450,
   parameter int M  = 450,
   parameter int CH = 3,
   parameter int AW = 21
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          l_valid,
   output logic          l_ready,
   input  logic [7:0]    l_data,
   input  logic          r_valid,
   output logic          r_ready,
   input  logic [7:0]    r_data,
   input  logic          kp_valid,
   input  logic [31:0]   kp_left,
   input  logic [31:0]   kp_right,
   output logic          kp_err,
   output logic          mem_we,
   output logic [AW-1:0] mem_waddr,
   output logic [7:0]    mem_wdata,
   output logic          mem_re,
   output logic [AW-1:0] mem_raddr,
   input  logic [7:0]    mem_rdata,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [7:0]    out_data,
   output logic          out_last
);
   typedef enum logic [2:0] {STORE, WAIT_KP, DIV, BLEND, DRAIN} state_t;
   localparam logic [AW-1:0] TOT      = AW'(CH * N * M);
   localparam logic [AW-1:0] ROW      = AW'(CH * M);
   localparam logic [AW-1:0] CHW      = AW'(CH);
   localparam logic [AW-1:0] LAST_ROW = AW'(N - 1);
   localparam logic [AW-1:0] ONE      = AW'(1);
   localparam logic [31:0]   NM       = 32'(N * M);
   localparam logic [31:0]   MW       = 32'(M);
   localparam logic          LEFT     = 1'b0;

   state_t        st;
   logic [AW-1:0] lcnt, rcnt, c1, wm1, off, o, q, rbase;
   logic [31:0]   a1, a2;
   logic          ptr, inflight, inflight_last;
   logic [7:0]    fd [4];
   logic          fl [4];
   logic [1:0]    wp, rp;
   logic [2:0]    cnt;
   logic          ldone, rdone, l_acc, r_acc, pop;

   assign ldone     = lcnt == TOT;
   assign rdone     = rcnt == TOT;
   assign l_ready   = rst_n && st == STORE && !ldone && (!r_valid || rdone || ptr == LEFT);
   assign r_ready   = rst_n && st == STORE && !rdone && (!l_valid || ldone || ptr != LEFT);
   assign l_acc     = l_valid && l_ready;
   assign r_acc     = r_valid && r_ready;
   assign mem_re    = st == BLEND && (4'(cnt) + 4'(inflight) < 4'd4);
   assign mem_raddr = rbase + q + (q < c1 ? '0 : off);
   assign out_valid = cnt != 3'd0;
   assign out_data  = fd[rp];
   assign out_last  = out_valid && fl[rp];
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st            <= STORE;
         lcnt          <= '0;
         rcnt          <= '0;
         ptr           <= LEFT;
         a1            <= '0;
         a2            <= '0;
         c1            <= '0;
         wm1           <= '0;
         off           <= '0;
         o             <= '0;
         q             <= '0;
         rbase         <= '0;
         kp_err        <= 1'b0;
         mem_we        <= 1'b0;
         mem_waddr     <= '0;
         mem_wdata     <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         wp            <= '0;
         rp            <= '0;
         cnt           <= '0;
         for (int i = 0; i < 4; i++) begin
            fd[i] <= '0;
            fl[i] <= 1'b0;
         end
      end else begin
         mem_we <= l_acc || r_acc;
         if (l_acc || r_acc) begin
            mem_waddr <= l_acc ? lcnt : TOT + rcnt;
            mem_wdata <= l_acc ? l_data : r_data;
         end
         kp_err        <= st == WAIT_KP && kp_valid && (kp_left >= NM || kp_right >= NM);
         inflight      <= mem_re;
         inflight_last <= mem_re && o == LAST_ROW && q == wm1;
         if (inflight) begin
            fd[wp] <= mem_rdata;
            fl[wp] <= inflight_last;
            wp     <= wp + 2'd1;
         end
         if (pop)
            rp <= rp + 2'd1;
         cnt <= cnt + 3'(inflight) - 3'(pop);
         case (st)
            STORE: begin
               if (l_acc)
                  lcnt <= lcnt + ONE;
               if (r_acc)
                  rcnt <= rcnt + ONE;
               if (l_valid && !ldone && r_valid && !rdone)
                  ptr <= !ptr;
               if (ldone && rdone)
                  st <= WAIT_KP;
            end
            WAIT_KP: begin
               if (kp_valid && kp_left < NM && kp_right < NM) begin
                  a1 <= kp_left;
                  a2 <= kp_right;
                  st <= DIV;
               end
            end
            DIV: begin
               if (a1 >= MW)
                  a1 <= a1 - MW;
               if (a2 >= MW)
                  a2 <= a2 - MW;
               if (a1 < MW && a2 < MW) begin
                  c1    <= CHW * a1[AW-1:0];
                  wm1   <= CHW * a1[AW-1:0] + ROW - CHW * a2[AW-1:0] - ONE;
                  off   <= TOT + CHW * a2[AW-1:0] - CHW * a1[AW-1:0];
                  o     <= '0;
                  q     <= '0;
                  rbase <= '0;
                  st    <= BLEND;
               end
            end
            BLEND: begin
               if (mem_re) begin
                  q <= q == wm1 ? '0 : q + ONE;
                  if (q == wm1) begin
                     o     <= o + ONE;
                     rbase <= rbase + ROW;
                     if (o == LAST_ROW)
                        st <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (pop && fl[rp]) begin
                  lcnt <= '0;
                  rcnt <= '0;
                  ptr  <= LEFT;
                  st   <= STORE;
               end
            end
            default: st <= STORE;
         endcase
      end
   end
endmodule

// File: tb/tb_stitch_sched.sv
// tb_stitch_sched: directed frames against a byte-level model of store, split and blend for N=2, M=4, CH=3
module tb_stitch_sched;
   localparam int N = 2, M = 4, CH = 3, AW = 8, TOT = CH * N * M;

   logic          clk = 0, rst_n = 0;
   logic          l_valid = 0, r_valid = 0, kp_valid = 0, out_ready = 0;
   logic [7:0]    l_data = 0, r_data = 0, mem_rdata = 0;
   logic [31:0]   kp_left = 0, kp_right = 0;
   logic          l_ready, r_ready, kp_err, mem_we, mem_re, out_valid, out_last;
   logic [AW-1:0] mem_waddr, mem_raddr;
   logic [7:0]    mem_wdata, out_data;

   stitch_sched #(.N(N), .M(M), .CH(CH), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .l_valid(l_valid), .l_ready(l_ready), .l_data(l_data),
      .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
      .kp_valid(kp_valid), .kp_left(kp_left), .kp_right(kp_right), .kp_err(kp_err),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
   );

   always #5 clk = ~clk;

   int checks = 0, passes = 0, cyc = 0, rmode = 0;
   logic [7:0] limg [TOT];
   logic [7:0] rimg [TOT];
   logic [7:0] ram [2*TOT];
   int wqa[$], wqd[$], exp_ra[$], exp_d[$], exp_l[$], rlog[$], wlog[$], glog[$];
   int lacc_n = 0, racc_n = 0, issued = 0, popped = 0, max_out = 0, nbytes = 0;
   int first_re = -1, first_ov = -1, first_pop = -1, last_pop = -1, store_cyc = 0;
   bit frame_done = 0;
   int r3 [9] = '{0, 1, 2, 30, 31, 32, 33, 34, 35};

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic int at(input int qq[$], input int i);
      return i < qq.size() ? qq[i] : -1;
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_we) ram[mem_waddr] <= mem_wdata;
      mem_rdata <= mem_re ? ram[mem_raddr] : 8'h00;
   end

   always begin
      @(posedge clk);
      #1;
      out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? ((cyc % 20 < 10) ? cyc[0] : 1'b0) : 1'b0;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         wqa.delete(); wqd.delete(); exp_ra.delete(); exp_d.delete(); exp_l.delete();
         lacc_n = 0; racc_n = 0; issued = 0; popped = 0;
      end else begin
         if (mem_we || wqa.size() != 0) begin
            if (wqa.size() == 0) chk("spurious_write", int'(mem_we), 0);
            else begin
               chk("mem_we", int'(mem_we), 1);
               chk("waddr", int'(mem_waddr), wqa[0]);
               chk("wdata", int'(mem_wdata), wqd[0]);
               wlog.push_back(int'(mem_waddr));
               void'(wqa.pop_front()); void'(wqd.pop_front());
            end
         end
         if ((l_valid && l_ready) || (r_valid && r_ready))
            chk("accepts_per_cycle", int'(l_valid && l_ready) + int'(r_valid && r_ready), 1);
         if (l_valid && l_ready) begin
            wqa.push_back(lacc_n); wqd.push_back(int'(l_data)); lacc_n++;
         end
         if (r_valid && r_ready) begin
            wqa.push_back(TOT + racc_n); wqd.push_back(int'(r_data)); racc_n++;
         end
         if (mem_re) begin
            chk("outstanding_lt4", int'(issued - popped < 4), 1);
            if (exp_ra.size() == 0) chk("raddr_unexpected", int'(mem_raddr), -1);
            else begin
               chk("raddr", int'(mem_raddr), exp_ra[0]);
               void'(exp_ra.pop_front());
            end
            rlog.push_back(int'(mem_raddr));
            if (first_re < 0) first_re = cyc;
            issued++;
            if (issued - popped > max_out) max_out = issued - popped;
         end
         if (out_valid && first_ov < 0) first_ov = cyc;
         if (out_valid && out_ready) begin
            if (exp_d.size() == 0) chk("out_unexpected", int'(out_data), -1);
            else begin
               chk("out_data", int'(out_data), exp_d[0]);
               chk("out_last", int'(out_last), exp_l[0]);
               void'(exp_d.pop_front()); void'(exp_l.pop_front());
            end
            popped++; nbytes++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            if (out_last) begin
               frame_done = 1; lacc_n = 0; racc_n = 0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic new_frame();
      rlog.delete(); wlog.delete();
      nbytes = 0; first_re = -1; first_ov = -1; first_pop = -1; last_pop = -1;
      frame_done = 0; max_out = 0; issued = 0; popped = 0;
   endtask

   task automatic plan(input int kl, input int kr);
      int c1, c2, w;
      c1 = CH * (kl % M);
      c2 = CH * (kr % M);
      w  = c1 + CH * M - c2;
      for (int o = 0; o < N; o++)
         for (int q = 0; q < w; q++) begin
            exp_ra.push_back(q < c1 ? o * CH * M + q : TOT + o * CH * M + c2 + q - c1);
            exp_d.push_back(int'(q < c1 ? limg[o * CH * M + q] : rimg[o * CH * M + c2 + q - c1]));
            exp_l.push_back(int'(o == N - 1 && q == w - 1));
         end
   endtask

   task automatic do_store(input int mode);
      int li, ri;
      bit la, ra;
      li = 0; ri = 0; store_cyc = 0; glog.delete();
      while ((li < TOT || ri < TOT) && store_cyc < 200) begin
         l_valid = 1;
         r_valid = mode == 1 ? 1'b1 : li >= TOT;
         l_data  = li < TOT ? limg[li] : 8'hEE;
         r_data  = ri < TOT ? rimg[ri] : 8'hEE;
         @(negedge clk);
         la = l_valid && l_ready;
         ra = r_valid && r_ready;
         if (la) glog.push_back(0);
         if (ra) glog.push_back(1);
         tick();
         li += int'(la); ri += int'(ra); store_cyc++;
      end
      chk("store_in_time", int'(store_cyc < 200), 1);
      @(negedge clk);
      chk("l_ready_after_done", int'(l_ready), 0);
      chk("r_ready_after_done", int'(r_ready), 0);
      l_valid = 0; r_valid = 0;
      tick(); tick();
   endtask

   task automatic kp(input int kl, input int kr, input int bad);
      kp_valid = 1; kp_left = kl; kp_right = kr;
      tick();
      kp_valid = 0;
      @(negedge clk);
      chk("kp_err_pulse", int'(kp_err), bad);
      tick();
      @(negedge clk);
      chk("kp_err_clear", int'(kp_err), 0);
      tick();
   endtask

   task automatic wait_frame();
      int n;
      n = 0;
      while (!frame_done && n < 400) begin
         tick(); n++;
      end
      chk("frame_done", int'(frame_done), 1);
      tick();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_l_ready"}, int'(l_ready), 0);
      chk({tag, "_r_ready"}, int'(r_ready), 0);
      chk({tag, "_kp_err"}, int'(kp_err), 0);
      chk({tag, "_mem_we"}, int'(mem_we), 0);
      chk({tag, "_mem_waddr"}, int'(mem_waddr), 0);
      chk({tag, "_mem_wdata"}, int'(mem_wdata), 0);
      chk({tag, "_mem_re"}, int'(mem_re), 0);
      chk({tag, "_mem_raddr"}, int'(mem_raddr), 0);
      chk({tag, "_out_valid"}, int'(out_valid), 0);
      chk({tag, "_out_data"}, int'(out_data), 0);
      chk({tag, "_out_last"}, int'(out_last), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: run still active, expected to have finished");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < TOT; i++) begin
         limg[i] = 8'(i + 1);
         rimg[i] = 8'(160 + i);
      end
      #12;
      check_zero("reset");
      @(posedge clk); #1 rst_n = 1;
      tick();

      new_frame();
      kp(5, 6, 0);
      do_store(1);
      chk("store_cycles_tie", store_cyc, 48);
      chk("grant0", at(glog, 0), 0);
      chk("grant1", at(glog, 1), 1);
      chk("grant2", at(glog, 2), 0);
      chk("grant3", at(glog, 3), 1);
      chk("waddr0", at(wlog, 0), 0);
      chk("waddr1", at(wlog, 1), 24);
      chk("waddr2", at(wlog, 2), 1);
      chk("waddr3", at(wlog, 3), 25);
      kp(8, 5, 1);
      kp(3, 8, 1);
      plan(5, 6);
      kp(5, 6, 0);
      wait_frame();
      chk("frame_a_bytes", nbytes, 18);
      for (int i = 0; i < 9; i++) chk("row0_raddr", at(rlog, i), r3[i]);
      chk("first_byte_latency", first_ov - first_re, 2);
      chk("sustained_rate", last_pop - first_pop, 17);

      new_frame();
      rmode = 1;
      do_store(2);
      chk("store_cycles_seq", store_cyc, 48);
      chk("left_last_waddr", at(wlog, 23), 23);
      chk("right_first_waddr", at(wlog, 24), 24);
      plan(5, 6);
      kp(5, 6, 0);
      wait_frame();
      chk("frame_b_bytes", nbytes, 18);
      chk("max_outstanding", max_out, 4);

      new_frame();
      rmode = 0;
      do_store(1);
      plan(0, 7);
      kp(0, 7, 0);
      wait_frame();
      chk("frame_c_bytes", nbytes, 6);

      new_frame();
      rmode = 2;
      do_store(1);
      plan(7, 4);
      kp(7, 4, 0);
      for (int n = 0; n < 100 && issued < 2; n++) tick();
      chk("blend_reached", int'(issued >= 2), 1);
      rst_n = 0;
      #1;
      check_zero("abort");
      tick(); tick();
      rst_n = 1;
      rmode = 0;
      tick();
      new_frame();
      do_store(1);
      chk("grant_after_reset", at(glog, 0), 0);
      chk("waddr_after_reset", at(wlog, 0), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
